// File: rtl/first_level_dot.sv
// ============================================================================
// first_level_dot
// ----------------------------------------------------------------------------
// First stage of the compute tree. Holds one activation vector from dataload,
// then takes BEATS weight words, one per weight_valid pulse. It accumulates a
// signed INT8 dot product over BEATS*LANES element pairs and emits one ACC_W
// result for each activation vector.
//
// Protocol errors set err_o, which stays set until reset:
//   - a weight word that arrives while no vector is loaded is discarded;
//   - a weight word that arrives together with a new vector is discarded;
//   - a new vector that arrives mid-run aborts the run and restarts on the new
//     vector.
// ============================================================================
module first_level_dot #(
    parameter int BEATS  = 8,   // weight words per dot product
    parameter int LANES  = 4,   // elements per weight word
    parameter int ELEM_W = 8,   // element width, two's complement
    parameter int ACC_W  = 32   // accumulator / result width
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [BEATS*LANES*ELEM_W-1:0]   first_level_input_data,
    input  logic                            input_valid,
    input  logic [LANES*ELEM_W-1:0]         weight_i,
    input  logic                            weight_valid,
    output logic [ACC_W-1:0]                result_o,
    output logic                            result_valid_o,
    output logic                            busy_o,
    output logic                            err_o
);

    localparam int ACT_W  = BEATS * LANES * ELEM_W;
    localparam int WGT_W  = LANES * ELEM_W;
    localparam int PROD_W = 2 * ELEM_W;
    localparam int CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // ------------------------------------------------------------------------
    // State registers and their next-state values
    // ------------------------------------------------------------------------
    state_t                  state,        state_next;
    logic [CNT_W-1:0]        beat_cnt,     beat_cnt_next;
    logic signed [ACC_W-1:0] acc,          acc_next;
    logic [ACT_W-1:0]        act_reg,      act_reg_next;
    logic [ACC_W-1:0]        result_next;
    logic                    result_valid_next;
    logic                    err_next;

    // Sum of this beat's products, and the accumulator after adding it.
    logic signed [ACC_W-1:0] beat_sum;
    logic signed [ACC_W-1:0] acc_sum;

    // ------------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------------

    // Sum of the LANES products for the current beat, at full precision.
    // Weight lane j is multiplied by activation element LANES*beat_cnt + j.
    always_comb begin
        logic signed [ELEM_W-1:0] w_elem;
        logic signed [ELEM_W-1:0] a_elem;
        logic signed [PROD_W-1:0] prod;
        // NOTE: every variable written in a combinational block gets a default
        // at the top of the block. Without it, any path that skips the
        // assignment makes synthesis infer a latch.
        beat_sum = '0;
        w_elem   = '0;
        a_elem   = '0;
        prod     = '0;
        for (int j = 0; j < LANES; j++) begin
            w_elem   = weight_i[j*ELEM_W +: ELEM_W];
            a_elem   = act_reg[(int'(beat_cnt) * LANES + j) * ELEM_W +: ELEM_W];
            prod     = w_elem * a_elem;
            beat_sum = beat_sum + {{(ACC_W - PROD_W){prod[PROD_W-1]}}, prod};
        end
    end

    // The accumulator wraps on overflow. It does not saturate.
    assign acc_sum = acc + beat_sum;

    // ------------------------------------------------------------------------
    // Control
    // ------------------------------------------------------------------------

    // Next-state, counter, accumulator and output decode for the IDLE/RUN FSM.
    always_comb begin
        state_next        = state;
        beat_cnt_next     = beat_cnt;
        acc_next          = acc;
        act_reg_next      = act_reg;
        result_next       = result_o;
        result_valid_next = 1'b0;
        err_next          = err_o;

        unique case (state)
            IDLE: begin
                if (input_valid) begin
                    act_reg_next  = first_level_input_data;
                    acc_next      = '0;
                    beat_cnt_next = '0;
                    state_next    = RUN;
                    // A weight word in the same cycle as the vector belongs to
                    // no vector, so it is dropped.
                    if (weight_valid) begin
                        err_next = 1'b1;
                    end
                end else if (weight_valid) begin
                    // No vector is loaded, so the weight word is dropped.
                    err_next = 1'b1;
                end
            end

            RUN: begin
                if (input_valid) begin
                    // Abort. Restart on the new vector and keep the old result.
                    act_reg_next  = first_level_input_data;
                    acc_next      = '0;
                    beat_cnt_next = '0;
                    err_next      = 1'b1;
                end else if (weight_valid) begin
                    acc_next = acc_sum;
                    if (beat_cnt == LAST_BEAT) begin
                        result_next       = acc_sum;
                        result_valid_next = 1'b1;
                        beat_cnt_next     = '0;
                        state_next        = IDLE;
                    end else begin
                        beat_cnt_next = beat_cnt + CNT_W'(1);
                    end
                end
                // With no valid input the FSM holds. There is no timeout
                // between beats.
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State registers, all cleared by the asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            beat_cnt       <= '0;
            acc            <= '0;
            act_reg        <= '0;
            result_o       <= '0;
            result_valid_o <= 1'b0;
            err_o          <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments. Every
            // flop then samples its pre-edge value, whatever the order of
            // the statements.
            state          <= state_next;
            beat_cnt       <= beat_cnt_next;
            acc            <= acc_next;
            act_reg        <= act_reg_next;
            result_o       <= result_next;
            result_valid_o <= result_valid_next;
            err_o          <= err_next;
        end
    end

    // The state register is a flop, so busy_o is a registered output.
    assign busy_o = (state == RUN);

    // Keep WGT_W referenced so the derived width stays visible next to ACT_W.
    logic unused_wgt_w;
    assign unused_wgt_w = (WGT_W == LANES * ELEM_W);

endmodule
